// File: rtl/efi_wheel_pkg.sv
// Shared types and constants for the missing-tooth crank wheel generator.
// The CRANK_WHEEL_GEN_CAM_EN option is handled in crank_wheel_gen, not here.
package efi_wheel_pkg;

   localparam int DEF_PERIOD_W = 32;
   localparam int DEF_TOOTH_W  = 16;

   localparam int MIN_TEETH  = 2;
   localparam int MIN_PERIOD = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TOOTH_HI = 2'd1,
      TOOTH_LO = 2'd2,
      GAP      = 2'd3
   } wheel_state_t;

   // Snapshot of one revolution's wheel geometry, at the default widths.
   typedef struct packed {
      logic [DEF_TOOTH_W-1:0]  tooth_cnt;
      logic [DEF_TOOTH_W-1:0]  teeth_missing;
      logic [DEF_PERIOD_W-1:0] tooth_period;
   } wheel_cfg_t;

endpackage

// File: rtl/wheel_period_timer.sv
// Up-counter shared by the HI, LO and GAP phases: start restarts the count at 0,
// done flags the last cycle of a len-cycle interval.
module wheel_period_timer
   import efi_wheel_pkg::*;
#(
   parameter int PERIOD_W = DEF_PERIOD_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [PERIOD_W-1:0] len,
   output logic                done
);

   logic [PERIOD_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + PERIOD_W'(1);
      end
   end

   assign done = (cnt_q == len - PERIOD_W'(1));

endmodule

// File: rtl/crank_wheel_gen.sv
// N-M missing-tooth crank trigger generator; config is relatched only at revolution
// boundaries. Define CRANK_WHEEL_GEN_CAM_EN to add a once-per-720-degree cam pulse.
module crank_wheel_gen
   import efi_wheel_pkg::*;
#(
   parameter int PERIOD_W = DEF_PERIOD_W,
   parameter int TOOTH_W  = DEF_TOOTH_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [TOOTH_W-1:0]  tooth_cnt,
   input  logic [TOOTH_W-1:0]  teeth_missing,
   input  logic [PERIOD_W-1:0] tooth_period,
   output logic                vr_out,
   output logic [TOOTH_W-1:0]  tooth_idx,
   output logic                rev_strobe,
   output logic                cfg_err,
   output logic                cam_out
);

   wheel_state_t        state_q, state_d;
   logic [TOOTH_W-1:0]  n_q, m_q;
   logic [PERIOD_W-1:0] p_q;
   logic [TOOTH_W-1:0]  idx_q, idx_d;
   logic [TOOTH_W-1:0]  gap_q, gap_d;
   logic                rev_q, rev_d;
   logic                err_q, err_d;
   logic                latch_cfg, boundary;
   logic                cfg_ok;
   logic                tmr_start, tmr_done;
   logic [PERIOD_W-1:0] tmr_len, hi_len, lo_len;
   logic [TOOTH_W-1:0]  last_idx, last_gap;

   // Validity is judged on the live inputs, since they are what would be latched.
   assign cfg_ok = (tooth_cnt >= TOOTH_W'(MIN_TEETH)) &&
                   (teeth_missing < tooth_cnt) &&
                   (tooth_period >= PERIOD_W'(MIN_PERIOD));

   assign last_idx = n_q - m_q - TOOTH_W'(1);
   assign last_gap = m_q - TOOTH_W'(1);
   assign hi_len   = p_q >> 1;
   assign lo_len   = p_q - hi_len;

   wheel_period_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (tmr_start),
      .len   (tmr_len),
      .done  (tmr_done)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      err_d     = err_q;
      rev_d     = 1'b0;
      latch_cfg = 1'b0;
      boundary  = 1'b0;
      tmr_start = 1'b0;
      tmr_len   = hi_len;
      if (!en) begin
         state_d   = IDLE;
         idx_d     = '0;
         gap_d     = '0;
         err_d     = 1'b0;
         tmr_start = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               tmr_start = 1'b1;
               if (cfg_ok) begin
                  latch_cfg = 1'b1;
                  state_d   = TOOTH_HI;
                  idx_d     = '0;
                  rev_d     = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            TOOTH_HI: begin
               tmr_len = hi_len;
               if (tmr_done) begin
                  tmr_start = 1'b1;
                  state_d   = TOOTH_LO;
               end
            end
            TOOTH_LO: begin
               tmr_len = lo_len;
               if (tmr_done) begin
                  tmr_start = 1'b1;
                  if (idx_q < last_idx) begin
                     idx_d   = idx_q + TOOTH_W'(1);
                     state_d = TOOTH_HI;
                  end else if (m_q != '0) begin
                     gap_d   = '0;
                     state_d = GAP;
                  end else begin
                     boundary = 1'b1;
                  end
               end
            end
            GAP: begin
               // The gap is M whole tooth periods, counted one period at a time.
               tmr_len = p_q;
               if (tmr_done) begin
                  tmr_start = 1'b1;
                  if (gap_q == last_gap) begin
                     boundary = 1'b1;
                  end else begin
                     gap_d = gap_q + TOOTH_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
         if (boundary) begin
            idx_d = '0;
            gap_d = '0;
            if (cfg_ok) begin
               latch_cfg = 1'b1;
               state_d   = TOOTH_HI;
               rev_d     = 1'b1;
            end else begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         gap_q   <= '0;
         n_q     <= '0;
         m_q     <= '0;
         p_q     <= '0;
         rev_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         rev_q   <= rev_d;
         err_q   <= err_d;
         if (latch_cfg) begin
            n_q <= tooth_cnt;
            m_q <= teeth_missing;
            p_q <= tooth_period;
         end
      end
   end

   assign vr_out     = (state_q == TOOTH_HI);
   assign tooth_idx  = idx_q;
   assign rev_strobe = rev_q;
   assign cfg_err    = err_q;

`ifdef CRANK_WHEEL_GEN_CAM_EN
   logic parity_q;

   // Parity 0 marks the even revolutions, the first one after IDLE included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else if (state_d == IDLE) begin
         parity_q <= 1'b0;
      end else if (boundary && cfg_ok) begin
         parity_q <= ~parity_q;
      end
   end

   assign cam_out = vr_out && (idx_q == '0) && !parity_q;
`else
   assign cam_out = 1'b0;
`endif

endmodule
